// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in parallel-out receiver with a double-buffered output
// word, a valid/ack handshake and sticky overrun detection.
// Optional feature: define SIPO_PARITY_EN to append one even-parity bit to each
// frame and expose the parity_err output.
module sipo_receiver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             serial_in,
  input  logic                             shift_c,
  input  logic                             clear_c,
  input  logic                             data_ack,
  output logic [WIDTH-1:0]                 data_out,
  output logic                             data_valid,
  output logic [$clog2(WIDTH+2)-1:0]       bit_count,
  output logic                             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic                             parity_err
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

`ifdef SIPO_PARITY_EN
  typedef enum logic [0:0] {S_DATA = 1'b0, S_PAR = 1'b1} state_t;
`else
  typedef enum logic [0:0] {S_DATA = 1'b0} state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next_c;
  logic             capture_c;
  logic             complete_c;
  logic             load_c;
  logic [WIDTH-1:0] word_c;

  // Shift register contents after capturing serial_in in the chosen bit order
  always_comb begin
    if (MSB_FIRST != 0) begin
      sr_next_c = {sr[WIDTH-2:0], serial_in};
    end else begin
      sr_next_c = {serial_in, sr[WIDTH-1:1]};
    end
  end

  // State register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DATA;
      bit_count <= '0;
    end else begin
      state_q   <= state_d;
      bit_count <= count_d;
    end
  end

  // Next-state logic; clear_c aborts the frame and drops a simultaneous bit
  always_comb begin
    state_d = state_q;
    count_d = bit_count;
    if (clear_c) begin
      state_d = S_DATA;
      count_d = '0;
    end else if (shift_c) begin
      case (state_q)
        S_DATA: begin
          if (bit_count == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            state_d = S_PAR;
            count_d = CW'(WIDTH);
`else
            state_d = S_DATA;
            count_d = '0;
`endif
          end else begin
            count_d = bit_count + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        S_PAR: begin
          state_d = S_DATA;
          count_d = '0;
        end
`endif
        default: begin
          state_d = S_DATA;
          count_d = '0;
        end
      endcase
    end
  end

  // Datapath strobes: data-bit capture, frame completion and word load
  always_comb begin
    capture_c  = 1'b0;
    complete_c = 1'b0;
    word_c     = sr_next_c;
    if (!clear_c && shift_c) begin
      case (state_q)
        S_DATA: begin
          capture_c = 1'b1;
`ifndef SIPO_PARITY_EN
          complete_c = (bit_count == CW'(WIDTH - 1));
`endif
        end
`ifdef SIPO_PARITY_EN
        S_PAR: begin
          complete_c = 1'b1;
          word_c     = sr;
        end
`endif
        default: begin
          capture_c = 1'b0;
        end
      endcase
    end
    load_c = complete_c && (!data_valid || data_ack);
  end

  // Shift register, output word, handshake and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (capture_c) begin
        sr <= sr_next_c;
      end
      if (load_c) begin
        data_out   <= word_c;
        data_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        parity_err <= ^{word_c, serial_in};
`endif
      end else if (complete_c) begin
        overrun <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
      if (clear_c) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed testbench for sipo_receiver: an MSB-first and an LSB-first instance
// share one stimulus stream. Parity checks are built when SIPO_PARITY_EN is set.
module tb_sipo_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       shift_c;
  logic       clear_c;
  logic       data_ack;
  logic [3:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [2:0] m_count, l_count;
  logic       m_ovr, l_ovr;
`ifdef SIPO_PARITY_EN
  logic       m_perr, l_perr;
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sipo_receiver #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_c(shift_c),
    .clear_c(clear_c), .data_ack(data_ack), .data_out(m_data),
    .data_valid(m_valid), .bit_count(m_count), .overrun(m_ovr)
`ifdef SIPO_PARITY_EN
    , .parity_err(m_perr)
`endif
  );

  sipo_receiver #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_c(shift_c),
    .clear_c(clear_c), .data_ack(data_ack), .data_out(l_data),
    .data_valid(l_valid), .bit_count(l_count), .overrun(l_ovr)
`ifdef SIPO_PARITY_EN
    , .parity_err(l_perr)
`endif
  );

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs settle 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send four bits (bits[3] first), then the parity bit when enabled
  task automatic send_frame(input logic [3:0] bits, input logic ack_last, input logic flip);
    for (int i = 3; i >= 0; i--) begin
      serial_in = bits[i];
      shift_c   = 1'b1;
      data_ack  = (i == 0 && !PAR_EN) ? ack_last : 1'b0;
      step();
    end
    if (PAR_EN) begin
      serial_in = (^bits) ^ flip;
      data_ack  = ack_last;
      step();
    end
    shift_c  = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; shift_c = 1'b0; clear_c = 1'b0; data_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_data", 32'(m_data), 32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_count", 32'(m_count), 32'h0);
    chk("rst_ovr", 32'(m_ovr), 32'h0);

    // Ack with nothing held is ignored
    pulse_ack();
    chk("idle_ack_valid", 32'(m_valid), 32'h0);

    // Test 1 / 2: bit order
    send_frame(4'b1011, 1'b0, 1'b0);
    chk("t1_msb_data", 32'(m_data), 32'hB);
    chk("t1_msb_valid", 32'(m_valid), 32'h1);
    chk("t1_msb_count", 32'(m_count), 32'h0);
    chk("t2_lsb_data", 32'(l_data), 32'hD);
    pulse_ack();
    chk("t2_lsb_valid", 32'(l_valid), 32'h0);
    chk("t2_lsb_hold", 32'(l_data), 32'hD);

    // Test 3: overrun and clear
    send_frame(4'b1011, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("t3_data_kept", 32'(m_data), 32'hB);
    chk("t3_ovr", 32'(m_ovr), 32'h1);
    clear_c = 1'b1;
    step();
    clear_c = 1'b0;
    chk("t3_clr_ovr", 32'(m_ovr), 32'h0);
    chk("t3_clr_valid", 32'(m_valid), 32'h1);
    chk("t3_clr_data", 32'(m_data), 32'hB);

    // Test 4: ack coincident with completion
    pulse_ack();
    send_frame(4'b1011, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1'b0);
    chk("t4_data", 32'(m_data), 32'h6);
    chk("t4_valid", 32'(m_valid), 32'h1);
    chk("t4_ovr", 32'(m_ovr), 32'h0);
    chk("t4_lsb_data", 32'(l_data), 32'h6);

    // Test 5: gaps, clear with shift, reset mid-frame
    pulse_ack();
    serial_in = 1'b1; shift_c = 1'b1;
    step();
    step();
    shift_c = 1'b0;
    chk("t5_count2", 32'(m_count), 32'h2);
    step(); step(); step();
    chk("t5_gap_count", 32'(m_count), 32'h2);
    clear_c = 1'b1; shift_c = 1'b1;
    step();
    clear_c = 1'b0; shift_c = 1'b0;
    chk("t5_clr_count", 32'(m_count), 32'h0);
    send_frame(4'b0011, 1'b0, 1'b0);
    chk("t5_data", 32'(m_data), 32'h3);
    chk("t5_lsb_data", 32'(l_data), 32'hC);
    serial_in = 1'b1; shift_c = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; shift_c = 1'b0;
    chk("t5_rst_data", 32'(m_data), 32'h0);
    chk("t5_rst_valid", 32'(m_valid), 32'h0);
    chk("t5_rst_count", 32'(m_count), 32'h0);
    chk("t5_rst_ovr", 32'(m_ovr), 32'h0);

`ifdef SIPO_PARITY_EN
    // Test 6: parity
    send_frame(4'b1011, 1'b0, 1'b0);
    chk("t6_data", 32'(m_data), 32'hB);
    chk("t6_perr_ok", 32'(m_perr), 32'h0);
    pulse_ack();
    send_frame(4'b1011, 1'b0, 1'b1);
    chk("t6_perr_bad", 32'(m_perr), 32'h1);
    chk("t6_lsb_perr_bad", 32'(l_perr), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in parallel-out receiver that reassembles the single-bit stream from the `piso` shifter's `c` line into WIDTH-bit words. It is the receiving end of the same serial link, typically fed by `piso` and handing words to downstream consumers such as the adder datapath. Reception is double-buffered: a shift register collects the next frame while the previously completed word is held on `data_out` under a valid/ack handshake. The block detects overruns and, optionally, checks a parity bit.

## Interface

Parameters:
- `WIDTH`, default 4: data bits per frame; must be at least 2.
- `MSB_FIRST`, default 1: 1 means the first received bit becomes `data_out[WIDTH-1]`; 0 means the first received bit becomes `data_out[0]`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `serial_in`  input  1: serial data, connected to `piso.c`.
- `shift_c`  input  1: sample strobe; `serial_in` is captured on a rising edge where `shift_c`=1.
- `clear_c`  input  1: aborts the partial frame and clears `overrun`.
- `data_ack`  input  1: consumer accepts `data_out`.
- `data_out`  output  WIDTH: last completed word.
- `data_valid`  output  1: `data_out` holds an unconsumed word.
- `bit_count`  output  $clog2(WIDTH+2): bits of the current frame received so far.
- `overrun`  output  1: sticky; a completed word was dropped.
- `parity_err`  output  1: present only with `SIPO_PARITY_EN`.

## Operation

- State machine:
  - `DATA`: counting data bits, `bit_count` runs from 0 to WIDTH-1.
  - `PAR`: awaiting the parity bit. This state exists only with the macro.
  - Without the macro, the WIDTH-th sampled bit completes the frame and the FSM returns to `DATA` with `bit_count`=0.
  - With the macro, the WIDTH-th bit moves the FSM to `PAR` with `bit_count`=WIDTH. The next sampled bit completes the frame and the FSM returns to `DATA`.
- Bit order and shift register:
  - `MSB_FIRST`=1: left shift, `sr <= {sr[WIDTH-2:0], serial_in}`.
  - `MSB_FIRST`=0: right shift, `sr <= {serial_in, sr[WIDTH-1:1]}`.
- Frame completion:
  - If `data_valid`=0, or `data_ack`=1 in the same cycle, the assembled word is loaded into `data_out` and `data_valid` is 1.
  - Otherwise the word is discarded, `data_out` is unchanged, and `overrun` is set to 1.
- Handshake:
  - `data_ack` with `data_valid`=1 and no completion in that cycle: `data_valid` goes to 0.
  - `data_ack` with `data_valid`=0 is ignored.
  - `data_out` holds its value after being consumed until the next load.
- `clear_c`:
  - Sets `bit_count` to 0, sets the FSM to `DATA`, and sets `overrun` to 0.
  - `data_out`, `data_valid` and `parity_err` are untouched.
  - `clear_c` wins over a simultaneous `shift_c`; that bit is dropped.
  - `clear_c` does not block a simultaneous `data_ack`.
- `shift_c`=0: the frame state is frozen. Gaps of any length between bits are legal.

## Timing

- Reset values: `data_out`=0, `data_valid`=0, `bit_count`=0, `overrun`=0, `parity_err`=0. The FSM resets to `DATA` and the shift register to 0.
- `rst` mid-frame discards the partial frame and any held word. `rst` overrides every other input.
- Latency: `data_valid` rises on the same edge that samples the last bit of the frame, which is the parity bit when `SIPO_PARITY_EN` is defined. There are no extra pipeline cycles.
- `bit_count` updates on every sampling edge.
- Back-to-back frames at one bit per cycle are sustained, provided the consumer acks within WIDTH cycles.
- Ack and completion on the same edge: the new word is loaded, `data_valid` stays 1, and `overrun` is not set.
- Inputs are synchronous to `clk`; no metastability handling is required.

## Configuration

- Macro: `SIPO_PARITY_EN`.
- Defined:
  - The frame is WIDTH data bits followed by one even-parity bit.
  - `parity_err` is registered at each word load with `^{word, parity_bit}`. It is meaningful only while `data_valid`=1.
  - A dropped (overrun) frame does not update `parity_err`.
- Undefined:
  - The `parity_err` port and the `PAR` state are absent.
  - The frame is exactly WIDTH bits.

## Test plan

1. Reset, then defaults (WIDTH=4, `MSB_FIRST`=1), shift in 1,0,1,1 → `data_out`=4'b1011, `data_valid`=1 after the 4th edge, `bit_count`=0.
2. Same bits with `MSB_FIRST`=0 → `data_out`=4'b1101. Then pulse `data_ack` → `data_valid`=0 and `data_out` still 4'b1101.
3. Receive 4'b1011 with no ack, then receive 4'b0110 → `data_out`=4'b1011 and `overrun`=1. Then `clear_c` → `overrun`=0 and `data_valid` still 1.
4. Receive 4'b1011, then 4'b0110 with `data_ack` on the 2nd frame's last edge → `data_out`=4'b0110, `data_valid`=1, `overrun`=0.
5. Shift two bits, then assert `clear_c` together with `shift_c` → `bit_count`=0. Then send 4'b0011 → `data_out`=4'b0011. Asserting `rst` mid-frame clears every output to 0.
6. `SIPO_PARITY_EN`: send 1,0,1,1 then parity 1 → `data_out`=4'b1011, `parity_err`=0. Send 1,0,1,1 then parity 0 → `parity_err`=1.
